// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// ALU operation codes and the instruction classifier used by decoder and sequencer.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,
        CL_JR    = 4'd1,
        CL_J     = 4'd2,
        CL_JAL   = 4'd3,
        CL_BEQ   = 4'd4,
        CL_ALUI  = 4'd5,
        CL_LW    = 4'd6,
        CL_SW    = 4'd7,
        CL_BAD   = 4'd8
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_SLT  = 6'h2A;
    localparam logic [5:0] ALU_NONE = 6'h00;

    function automatic instr_class_t classify(input logic [5:0] op, input logic [5:0] funct);
        instr_class_t cls;
        case (op)
            OP_RTYPE: cls = (funct == FUNCT_JR) ? CL_JR : CL_RTYPE;
            OP_J:     cls = CL_J;
            OP_JAL:   cls = CL_JAL;
            OP_BEQ:   cls = CL_BEQ;
            OP_ADDI,
            OP_SLTI,
            OP_ANDI,
            OP_ORI:   cls = CL_ALUI;
            OP_LW:    cls = CL_LW;
            OP_SW:    cls = CL_SW;
            default:  cls = CL_BAD;
        endcase
        return cls;
    endfunction

    function automatic logic [5:0] alu_op_of(input logic [5:0] op, input logic [5:0] funct);
        logic [5:0] alu;
        case (op)
            OP_RTYPE: alu = funct;
            OP_LW,
            OP_SW,
            OP_ADDI:  alu = ALU_ADD;
            OP_BEQ:   alu = ALU_SUB;
            OP_ANDI:  alu = ALU_AND;
            OP_ORI:   alu = ALU_OR;
            OP_SLTI:  alu = ALU_SLT;
            default:  alu = ALU_NONE;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational map from (state, OpCode, Funct) to datapath controls.
// Retirement is split into an unconditional part and a part that waits on memory.
module control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [2:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic       o_reg_dst,
    output logic       o_branch,
    output logic       o_jump_reg,
    output logic       o_jump,
    output logic       o_jal,
    output logic       o_and,
    output logic       o_mem_read,
    output logic       o_mem_to_reg,
    output logic       o_mem_write,
    output logic       o_immediate,
    output logic       o_reg_write,
    output logic       o_ir_write,
    output logic [5:0] o_alu_op,
    output logic       o_retire_now,
    output logic       o_retire_on_ready,
    output logic       o_busy,
    output logic       o_illegal
);

    instr_class_t w_class;
    logic         w_uses_imm;

    assign w_class    = classify(i_opcode, i_funct);
    assign w_uses_imm = (w_class == CL_ALUI) || (w_class == CL_LW) || (w_class == CL_SW);

    // Per-state output decode; every control defaults low.
    always_comb begin
        o_reg_dst         = 1'b0;
        o_branch          = 1'b0;
        o_jump_reg        = 1'b0;
        o_jump            = 1'b0;
        o_jal             = 1'b0;
        o_and             = 1'b0;
        o_mem_read        = 1'b0;
        o_mem_to_reg      = 1'b0;
        o_mem_write       = 1'b0;
        o_immediate       = 1'b0;
        o_reg_write       = 1'b0;
        o_ir_write        = 1'b0;
        o_retire_now      = 1'b0;
        o_retire_on_ready = 1'b0;
        o_busy            = 1'b0;
        o_illegal         = 1'b0;
        o_alu_op          = alu_op_of(i_opcode, i_funct);
        case (i_state)
            ST_FETCH: begin
                o_ir_write = 1'b1;
            end
            ST_DECODE: begin
                o_busy = 1'b1;
            end
            ST_EXEC: begin
                o_busy      = 1'b1;
                o_immediate = w_uses_imm;
                o_reg_dst   = (w_class == CL_RTYPE);
                case (w_class)
                    CL_BEQ: begin
                        o_branch     = 1'b1;
                        o_and        = 1'b1;
                        o_retire_now = 1'b1;
                    end
                    CL_J: begin
                        o_jump       = 1'b1;
                        o_retire_now = 1'b1;
                    end
                    CL_JAL: begin
                        o_jump       = 1'b1;
                        o_jal        = 1'b1;
                        o_reg_write  = 1'b1;
                        o_retire_now = 1'b1;
                    end
                    CL_JR: begin
                        o_jump_reg   = 1'b1;
                        o_retire_now = 1'b1;
                    end
                    default: begin
                        o_retire_now = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                o_busy            = 1'b1;
                o_immediate       = w_uses_imm;
                o_mem_read        = (w_class == CL_LW);
                o_mem_write       = (w_class == CL_SW);
                o_retire_on_ready = (w_class == CL_SW);
            end
            ST_WB: begin
                o_busy       = 1'b1;
                o_immediate  = w_uses_imm;
                o_reg_write  = 1'b1;
                o_reg_dst    = (w_class == CL_RTYPE);
                o_mem_to_reg = (w_class == CL_LW);
                o_retire_now = 1'b1;
            end
            ST_HALT: begin
                o_illegal = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: state register, next-state logic and the
// retired-instruction counter; output decode is delegated to control_decoder.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               RegDst,
    output logic               Branch,
    output logic               JumpReg,
    output logic               Jump,
    output logic               Jal,
    output logic               And,
    output logic               MemRead,
    output logic               MemToReg,
    output logic               MemWrite,
    output logic               Immediate,
    output logic               RegWrite,
    output logic               IrWrite,
    output logic               PcWrite,
    output logic [5:0]         AluOP,
    output logic               Busy,
    output logic               Illegal,
    output logic [COUNT_W-1:0] InstrCount
);

    state_t             r_state;
    logic [COUNT_W-1:0] r_instr_count;
    instr_class_t       w_class;

    logic w_reg_write, w_mem_read, w_mem_write, w_ir_write;
    logic w_jump, w_jal, w_branch, w_jump_reg;
    logic w_retire_now, w_retire_on_ready, w_retire;

    assign w_class  = classify(OpCode, Funct);
    assign w_retire = w_retire_now || (w_retire_on_ready && MemReady);

    control_decoder u_decoder (
        .i_state           (r_state),
        .i_opcode          (OpCode),
        .i_funct           (Funct),
        .o_reg_dst         (RegDst),
        .o_branch          (w_branch),
        .o_jump_reg        (w_jump_reg),
        .o_jump            (w_jump),
        .o_jal             (w_jal),
        .o_and             (And),
        .o_mem_read        (w_mem_read),
        .o_mem_to_reg      (MemToReg),
        .o_mem_write       (w_mem_write),
        .o_immediate       (Immediate),
        .o_reg_write       (w_reg_write),
        .o_ir_write        (w_ir_write),
        .o_alu_op          (AluOP),
        .o_retire_now      (w_retire_now),
        .o_retire_on_ready (w_retire_on_ready),
        .o_busy            (Busy),
        .o_illegal         (Illegal)
    );

    // Reset is synchronous, so enables are masked while it is high to keep an
    // in-flight access or retire from escaping during the reset cycle.
    assign RegWrite   = w_reg_write && !Reset;
    assign MemRead    = w_mem_read  && !Reset;
    assign MemWrite   = w_mem_write && !Reset;
    assign IrWrite    = w_ir_write  && !Reset;
    assign PcWrite    = w_retire    && !Reset;
    assign Jump       = w_jump      && !Reset;
    assign Jal        = w_jal       && !Reset;
    assign Branch     = w_branch    && !Reset;
    assign JumpReg    = w_jump_reg  && !Reset;
    assign InstrCount = r_instr_count;

    // State sequencing and retire counting; the counter wraps silently.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_FETCH;
            r_instr_count <= {COUNT_W{1'b0}};
        end else begin
            if (w_retire) begin
                r_instr_count <= r_instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: r_state <= (w_class == CL_BAD) ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    case (w_class)
                        CL_LW, CL_SW:      r_state <= ST_MEM;
                        CL_RTYPE, CL_ALUI: r_state <= ST_WB;
                        default:           r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (MemReady) begin
                        r_state <= (w_class == CL_LW) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed per-cycle expectations.
module tb_multicycle_control;

    localparam int COUNT_W = 4;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [5:0]         OpCode;
    logic [5:0]         Funct;
    logic               MemReady;
    logic               RegDst, Branch, JumpReg, Jump, Jal, And;
    logic               MemRead, MemToReg, MemWrite, Immediate, RegWrite;
    logic               IrWrite, PcWrite, Busy, Illegal;
    logic [5:0]         AluOP;
    logic [COUNT_W-1:0] InstrCount;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.COUNT_W(COUNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
        .RegDst(RegDst), .Branch(Branch), .JumpReg(JumpReg), .Jump(Jump), .Jal(Jal),
        .And(And), .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
        .Immediate(Immediate), .RegWrite(RegWrite), .IrWrite(IrWrite), .PcWrite(PcWrite),
        .AluOP(AluOP), .Busy(Busy), .Illegal(Illegal), .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the sample point of the next cycle (between edges).
    task automatic next_cyc();
        @(negedge Clk);
        #1;
    endtask

    // Leaves the bench at the sample point of cycle 1 (FETCH) of the next instruction.
    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        check_eq("rst_irwrite_gated", 32'(IrWrite), 32'd0);
        check_eq("rst_pcwrite_gated", 32'(PcWrite), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
    endtask

    initial begin
        int reads;
        int pcw;
        int writes;
        int ill;
        Reset = 1'b1; OpCode = 6'h00; Funct = 6'h00; MemReady = 1'b0;
        do_reset();
        check_eq("rst_count", 32'(InstrCount), 32'd0);
        check_eq("rst_illegal", 32'(Illegal), 32'd0);

        // addi: FETCH, DECODE, EXEC, WB(retire)
        OpCode = 6'h08;
        check_eq("addi_c1_irwrite", 32'(IrWrite), 32'd1);
        check_eq("addi_c1_busy", 32'(Busy), 32'd0);
        next_cyc();
        check_eq("addi_c2_busy", 32'(Busy), 32'd1);
        check_eq("addi_c2_irwrite", 32'(IrWrite), 32'd0);
        next_cyc();
        check_eq("addi_c3_aluop", 32'(AluOP), 32'h20);
        check_eq("addi_c3_imm", 32'(Immediate), 32'd1);
        check_eq("addi_c3_pcwrite", 32'(PcWrite), 32'd0);
        next_cyc();
        check_eq("addi_c4_regwrite", 32'(RegWrite), 32'd1);
        check_eq("addi_c4_pcwrite", 32'(PcWrite), 32'd1);
        check_eq("addi_c4_regdst", 32'(RegDst), 32'd0);
        next_cyc();
        check_eq("addi_count", 32'(InstrCount), 32'd1);

        // lw with MemReady low for three MEM cycles; MemReady pulse in DECODE is ignored
        OpCode = 6'h23;
        reads = 0; pcw = 0; writes = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) next_cyc();
            MemReady = (k == 7) || (k == 2);
            #1;
            reads  += int'(MemRead);
            pcw    += int'(PcWrite);
            writes += int'(MemWrite);
            if (k == 8) begin
                check_eq("lw_c8_memtoreg", 32'(MemToReg), 32'd1);
                check_eq("lw_c8_regwrite", 32'(RegWrite), 32'd1);
                check_eq("lw_c8_pcwrite", 32'(PcWrite), 32'd1);
            end
        end
        MemReady = 1'b0;
        check_eq("lw_memread_cycles", 32'(reads), 32'd4);
        check_eq("lw_pcwrite_cycles", 32'(pcw), 32'd1);
        check_eq("lw_memwrite_cycles", 32'(writes), 32'd0);
        next_cyc();
        check_eq("lw_count", 32'(InstrCount), 32'd2);

        // jal retires in EXEC
        OpCode = 6'h03;
        next_cyc();
        next_cyc();
        check_eq("jal_c3_jump", 32'(Jump), 32'd1);
        check_eq("jal_c3_jal", 32'(Jal), 32'd1);
        check_eq("jal_c3_regwrite", 32'(RegWrite), 32'd1);
        check_eq("jal_c3_pcwrite", 32'(PcWrite), 32'd1);
        next_cyc();
        check_eq("jal_c4_fetch_irwrite", 32'(IrWrite), 32'd1);
        check_eq("jal_c4_busy", 32'(Busy), 32'd0);
        check_eq("jal_count", 32'(InstrCount), 32'd3);

        // unknown opcode: HALT after DECODE, sticky
        OpCode = 6'h3F;
        next_cyc();
        check_eq("bad_c2_illegal", 32'(Illegal), 32'd0);
        ill = 0; pcw = 0; writes = 0;
        for (int k = 3; k <= 8; k++) begin
            next_cyc();
            MemReady = (k == 5);
            #1;
            ill    += int'(Illegal);
            pcw    += int'(PcWrite);
            writes += int'(RegWrite) + int'(MemWrite) + int'(MemRead) + int'(IrWrite) + int'(Busy);
        end
        MemReady = 1'b0;
        check_eq("halt_illegal_sticky", 32'(ill), 32'd6);
        check_eq("halt_pcwrite", 32'(pcw), 32'd0);
        check_eq("halt_enables_busy", 32'(writes), 32'd0);
        check_eq("halt_count_frozen", 32'(InstrCount), 32'd3);
        do_reset();
        check_eq("halt_rst_illegal", 32'(Illegal), 32'd0);
        check_eq("halt_rst_fetch", 32'(IrWrite), 32'd1);
        check_eq("halt_rst_count", 32'(InstrCount), 32'd0);

        // sw interrupted by Reset while waiting in MEM
        OpCode = 6'h2B;
        next_cyc();
        next_cyc();
        next_cyc();
        check_eq("sw_c4_memwrite", 32'(MemWrite), 32'd1);
        check_eq("sw_c4_memread", 32'(MemRead), 32'd0);
        check_eq("sw_c4_regwrite", 32'(RegWrite), 32'd0);
        next_cyc();
        check_eq("sw_c5_memwrite", 32'(MemWrite), 32'd1);
        Reset = 1'b1;
        MemReady = 1'b1;
        #1;
        check_eq("sw_rst_pcwrite", 32'(PcWrite), 32'd0);
        check_eq("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        next_cyc();
        check_eq("sw_after_edge_memwrite", 32'(MemWrite), 32'd0);
        check_eq("sw_after_edge_count", 32'(InstrCount), 32'd0);
        Reset = 1'b0;
        MemReady = 1'b0;
        #1;
        check_eq("sw_release_fetch", 32'(IrWrite), 32'd1);
        check_eq("sw_release_memwrite", 32'(MemWrite), 32'd0);
        check_eq("sw_release_count", 32'(InstrCount), 32'd0);

        // 15 control-flow retires bring the 4-bit counter to all-ones
        for (int i = 0; i < 15; i++) begin
            if (i == 13) begin
                OpCode = 6'h04; Funct = 6'h00;
            end else if (i == 14) begin
                OpCode = 6'h00; Funct = 6'h08;
            end else begin
                OpCode = 6'h02; Funct = 6'h00;
            end
            next_cyc();
            next_cyc();
            if (i == 13) begin
                check_eq("beq_branch", 32'(Branch), 32'd1);
                check_eq("beq_and", 32'(And), 32'd1);
                check_eq("beq_aluop", 32'(AluOP), 32'h22);
            end else if (i == 14) begin
                check_eq("jr_jumpreg", 32'(JumpReg), 32'd1);
                check_eq("jr_jump", 32'(Jump), 32'd0);
                check_eq("jr_regwrite", 32'(RegWrite), 32'd0);
            end else if (i == 0) begin
                check_eq("j_jump", 32'(Jump), 32'd1);
                check_eq("j_pcwrite", 32'(PcWrite), 32'd1);
            end
            next_cyc();
        end
        check_eq("count_all_ones", 32'(InstrCount), 32'hF);

        // R-type add wraps the counter
        OpCode = 6'h00; Funct = 6'h20;
        next_cyc();
        next_cyc();
        check_eq("radd_c3_aluop", 32'(AluOP), 32'h20);
        check_eq("radd_c3_regdst", 32'(RegDst), 32'd1);
        check_eq("radd_c3_imm", 32'(Immediate), 32'd0);
        next_cyc();
        check_eq("radd_c4_pcwrite", 32'(PcWrite), 32'd1);
        check_eq("radd_c4_regwrite", 32'(RegWrite), 32'd1);
        next_cyc();
        check_eq("count_wrap", 32'(InstrCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter COUNT_W, default 32: width of the retired-instruction counter.
REQ-002 The block SHALL have the port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port OpCode, input, 6 bits: instruction bits [31:26] from the datapath.
REQ-005 The block SHALL have the port Funct, input, 6 bits: instruction bits [5:0].
REQ-006 The block SHALL have the port MemReady, input, 1 bit: data memory completes the current access this cycle.
REQ-007 The block SHALL have these outputs, 1 bit each: RegDst, Branch, JumpReg, Jump, Jal, And, MemRead, MemToReg, MemWrite, Immediate, RegWrite. They keep the datapath meanings.
REQ-008 The block SHALL have these outputs, 1 bit each: IrWrite (latch instruction) and PcWrite (advance PC).
REQ-009 The block SHALL have the port AluOP, output, 6 bits: ALU operation code.
REQ-010 The block SHALL have these outputs, 1 bit each: Busy (instruction in flight) and Illegal (sticky unknown-opcode flag).
REQ-011 The block SHALL have the port InstrCount, output, COUNT_W bits: number of retired instructions.

Function
REQ-012 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT. All outputs SHALL be decoded from the registered state plus OpCode/Funct.
REQ-013 FETCH SHALL assert IrWrite and go to DECODE.
REQ-014 DECODE SHALL go to EXEC for a supported opcode and to HALT otherwise.
REQ-015 Supported opcodes SHALL be: R 0x00 (jr when Funct=0x08), j 0x02, jal 0x03, beq 0x04, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B.
REQ-016 EXEC transitions SHALL be: lw/sw go to MEM; R-type (not jr), addi, slti, andi and ori go to WB; beq, j, jal and jr retire in EXEC and go to FETCH.
REQ-017 MEM SHALL assert MemRead (lw) or MemWrite (sw) and hold while MemReady=0.
REQ-018 With MemReady=1 in MEM, lw SHALL go to WB and sw SHALL retire and go to FETCH.
REQ-019 WB SHALL assert RegWrite and retire. RegDst=1 only for R-type; MemToReg=1 only for lw.
REQ-020 AluOP SHALL equal Funct for R-type. Otherwise it SHALL be: lw/sw/addi 0x20, beq 0x22, andi 0x24, ori 0x25, slti 0x2A.
REQ-021 Immediate SHALL be 1 for addi, slti, andi, ori, lw and sw in EXEC, MEM and WB.
REQ-022 In EXEC: beq SHALL assert Branch and And; j SHALL assert Jump; jal SHALL assert Jump and Jal; jr SHALL assert JumpReg.
REQ-023 Jal SHALL also assert RegWrite in its EXEC cycle.
REQ-024 PcWrite SHALL be asserted for exactly one cycle per instruction, in its retire cycle. InstrCount SHALL increment on that same edge.
REQ-025 Instruction latency in cycles SHALL be: R/I-ALU 4; beq/j/jal/jr 3; sw 4+N; lw 5+N, where N is the number of MEM cycles with MemReady=0.
REQ-026 InstrCount SHALL wrap from all-ones to 0 with no flag.
REQ-027 HALT SHALL be absorbing until Reset. In HALT, Illegal=1 and all write enables (RegWrite, MemWrite, MemRead, PcWrite, IrWrite) are 0.
REQ-028 Busy SHALL be 0 in FETCH and HALT, and 1 otherwise.
REQ-029 MemReady SHALL be ignored outside MEM.
REQ-030 The block SHALL never assert MemRead and MemWrite in the same cycle, nor RegWrite and MemWrite in the same cycle.

Reset
REQ-031 Reset=1 at a clock edge SHALL force: state FETCH, InstrCount 0, Illegal 0.
REQ-032 While Reset=1, all write enables and Jump/Branch/JumpReg/Jal SHALL be 0. The cycle after release behaves as FETCH.
REQ-033 Reset SHALL take priority over any in-flight MEM wait or retire. No PcWrite or InstrCount increment occurs on the reset edge.

Structure
REQ-034 Opcode constants, Funct 0x08, AluOP constants and the state encoding SHALL live in a shared package, mips_ctrl_pkg.
REQ-035 A single sub-module, control_decoder, SHALL implement the combinational map from (state, OpCode, Funct) to outputs. multicycle_control holds the state register, next-state logic and counter.

Verification
REQ-036 The bench SHALL cover: addi (0x08) after reset -> IrWrite in cycle 1, RegWrite and PcWrite in cycle 4, InstrCount=1, AluOP=0x20, Immediate=1.
REQ-037 The bench SHALL cover: lw (0x23) with MemReady low 3 cycles -> MemRead high 4 cycles, MemToReg and RegWrite in cycle 8, single PcWrite.
REQ-038 The bench SHALL cover: jal (0x03) -> Jump, Jal, RegWrite and PcWrite together in cycle 3; back in FETCH in cycle 4.
REQ-039 The bench SHALL cover: opcode 0x3F -> HALT after DECODE, Illegal=1 sticky, InstrCount frozen; Reset -> Illegal=0, state FETCH.
REQ-040 The bench SHALL cover: Reset asserted mid-MEM of sw -> no MemWrite after the edge, no PcWrite, InstrCount unchanged from its pre-reset value of 0.
REQ-041 The bench SHALL cover: preload InstrCount to all-ones (COUNT_W=4), retire one R-type -> InstrCount=0.
